dmem_arbiter: RTL and testbench

- Shares the single-port data memory between the single-cycle MIPS core and an external host port (program loader/debug DMA).
- CPU accesses complete combinationally in the same cycle when granted. Host accesses are word bursts with auto-incrementing address.
- The block stalls the core while a host burst owns the memory. A starvation counter bounds how long the host waits.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arbiter_burst_addr_gen.sv | 38 +++
 rtl/dmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared state encoding and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W       = 32;
    localparam int DMEM_DATA_W       = 32;
    localparam int DMEM_LEN_W        = 4;
    localparam int DMEM_STARVE_LIMIT = 4;

    typedef enum logic {
        IDLE       = 1'b0,
        HOST_BURST = 1'b1
    } arb_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_burst_addr_gen.sv
// Host burst address generator: latches base/length at grant, walks beats,
// flags the final beat. Address wraps modulo 2^ADDR_W.
module burst_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
            len_q  <= '0;
            beat_q <= '0;
        end else if (load) begin
            base_q <= base;
            len_q  <= len;
            beat_q <= '0;
        end else if (advance) begin
            beat_q <= last ? '0 : beat_q + LEN_W'(1);
        end
    end

    assign addr = base_q + ADDR_W'(beat_q);
    assign last = (beat_q == len_q);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the single-cycle core and a host burst port.
// Optional counters stall_cycles/host_beats exist when DMEM_ARB_STATS_EN is defined.
//
//   state      | meaning
//   IDLE       | CPU owns memory; host waits, starvation counter runs
//   HOST_BURST | host burst owns memory, one beat per cycle, CPU stalled
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int LEN_W        = DMEM_LEN_W,
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [LEN_W-1:0]  host_len,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_wack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              host_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       host_beats
`endif
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q;
    logic              burst_we_q;
    logic [SW-1:0]     starve_q;
    logic              in_burst;
    logic              starved;
    logic              grant;
    logic              cpu_serve;
    logic              last;
    logic [ADDR_W-1:0] burst_addr;

    assign in_burst  = (state_q == HOST_BURST);
    assign starved   = (starve_q == SW'(STARVE_LIMIT));
    assign grant     = !in_burst && host_req && (!cpu_req || starved);
    assign cpu_serve = !in_burst && cpu_req && !grant;
    assign cpu_stall = cpu_req && (in_burst || grant);
    assign cpu_rdata = mem_rdata;

    burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (grant),
        .advance (in_burst),
        .base    (host_addr),
        .len     (host_len),
        .addr    (burst_addr),
        .last    (last)
    );

    // Strobes stay low in the grant cycle: the CPU is stalled and the burst starts next cycle.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        host_wack = 1'b0;
        if (in_burst) begin
            mem_addr  = burst_addr;
            mem_wdata = host_wdata;
            mem_we    = burst_we_q;
            mem_re    = !burst_we_q;
            host_wack = burst_we_q;
        end else if (cpu_serve) begin
            mem_we = cpu_we;
            mem_re = !cpu_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            burst_we_q  <= 1'b0;
            starve_q    <= '0;
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
            host_done   <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_gnt    <= grant;
            host_rvalid <= in_burst && !burst_we_q;
            host_done   <= in_burst && last;
            if (in_burst && !burst_we_q)
                host_rdata <= mem_rdata;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q    <= HOST_BURST;
                        burst_we_q <= host_we;
                        starve_q   <= '0;
                    end else if (host_req && !starved) begin
                        starve_q <= starve_q + SW'(1);
                    end
                end
                HOST_BURST: begin
                    if (last)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            host_beats   <= '0;
        end else begin
            if (cpu_stall)
                stall_cycles <= sat_inc32(stall_cycles);
            if (in_burst)
                host_beats <= host_beats + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level memory model.
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [31:0] host_addr;
    logic [3:0]  host_len;
    logic [31:0] host_wdata, host_rdata;
    logic        host_gnt, host_wack, host_rvalid, host_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cycles, host_beats;
`endif

    logic [31:0] phys [0:255];
    logic [31:0] refm [0:255];
    logic        mem_init_done = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_wack(host_wack),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_done(host_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stall_cycles(stall_cycles), .host_beats(host_beats)
`endif
    );

    // 256-word data memory; upper address bits alias.
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) phys[i] <= 32'd0;
        end else if (mem_we) begin
            phys[mem_addr[7:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = phys[mem_addr[7:0]];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input bit req, input bit rnd);
        cpu_req   = req;
        cpu_we    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        cpu_addr  = rnd ? 32'($urandom_range(0, 255)) : 32'h80;
        cpu_wdata = $urandom;
    endtask

    // Called at negedge in a cycle where the CPU must be serviced.
    task automatic cpu_check();
        chk("cpu_stall_served", cpu_stall, 1'b0);
        if (cpu_we) begin
            chk("cpu_wr_we", mem_we, 1'b1);
            chk("cpu_wr_addr", mem_addr, cpu_addr);
            chk("cpu_wr_data", mem_wdata, cpu_wdata);
            refm[cpu_addr[7:0]] = cpu_wdata;
        end else begin
            chk("cpu_rd_re", mem_re, 1'b1);
            chk("cpu_rdata", cpu_rdata, refm[cpu_addr[7:0]]);
        end
    endtask

    task automatic idle_cycle(input bit rnd);
        drive_cpu(rnd ? 1'($urandom_range(0, 1)) : 1'b0, rnd);
        host_req = 1'b0;
        @(negedge clk);
        chk("idle_done", host_done, 1'b0);
        chk("idle_rvalid", host_rvalid, 1'b0);
        if (cpu_req) cpu_check();
        else chk("idle_strobes", {mem_we, mem_re}, 2'b00);
        next_cycle();
    endtask

    // One complete host burst, including the starvation wait when the CPU is busy.
    task automatic run_burst(input bit we, input logic [31:0] base, input logic [3:0] len,
                             input bit cpu_on, input bit rnd);
        logic [31:0] wd [0:15];
        logic [31:0] a;
        int          nwait;
        bit          creq;
        for (int k = 0; k < 16; k++) wd[k] = $urandom;
        host_req = 1'b1; host_we = we; host_addr = base; host_len = len; host_wdata = wd[0];
        nwait = cpu_on ? STARVE_LIMIT : 0;
        for (int c = 0; c < nwait; c++) begin
            drive_cpu(1'b1, rnd);
            @(negedge clk);
            chk("wait_gnt", host_gnt, 1'b0);
            cpu_check();
            next_cycle();
        end
        drive_cpu(cpu_on, rnd);
        @(negedge clk);
        chk("grant_stall", cpu_stall, cpu_on);
        chk("grant_strobes", {mem_we, mem_re}, 2'b00);
        chk("grant_early", host_gnt, 1'b0);
        next_cycle();
        for (int k = 0; k <= int'(len); k++) begin
            creq = rnd ? 1'($urandom_range(0, 1)) : cpu_on;
            drive_cpu(creq, rnd);
            host_wdata = wd[k];
            if (k > 0 && rnd) begin
                host_addr = $urandom; host_len = 4'($urandom); host_we = 1'($urandom);
            end
            @(negedge clk);
            a = base + 32'(k);
            chk("burst_gnt", host_gnt, (k == 0));
            chk("burst_addr", mem_addr, a);
            chk("burst_we", mem_we, we);
            chk("burst_re", mem_re, !we);
            chk("burst_wack", host_wack, we);
            chk("burst_stall", cpu_stall, creq);
            chk("burst_done", host_done, 1'b0);
            chk("burst_rvalid", host_rvalid, (!we && k > 0));
            if (we) begin
                chk("burst_wdata", mem_wdata, wd[k]);
                refm[a[7:0]] = wd[k];
            end else if (k > 0) begin
                a = base + 32'(k - 1);
                chk("burst_rdata", host_rdata, refm[a[7:0]]);
            end
            next_cycle();
            host_req = 1'b0;
        end
        drive_cpu(rnd ? 1'($urandom_range(0, 1)) : cpu_on, rnd);
        @(negedge clk);
        chk("end_done", host_done, 1'b1);
        chk("end_rvalid", host_rvalid, !we);
        chk("end_gnt", host_gnt, 1'b0);
        if (!we) begin
            a = base + 32'(len);
            chk("end_rdata", host_rdata, refm[a[7:0]]);
        end
        if (cpu_req) cpu_check();
        else chk("end_strobes", {mem_we, mem_re}, 2'b00);
        next_cycle();
        idle_cycle(1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 32'd0; host_len = 4'd0; host_wdata = 32'd0;
        @(negedge clk);
        chk("rst_gnt", host_gnt, 1'b0);
        chk("rst_rvalid", host_rvalid, 1'b0);
        chk("rst_done", host_done, 1'b0);
        chk("rst_rdata", host_rdata, 32'd0);
        chk("rst_strobes", {mem_we, mem_re}, 2'b00);
        chk("rst_stall", cpu_stall, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, refm[0]);
`ifdef DMEM_ARB_STATS_EN
        chk("rst_stall_cycles", stall_cycles, 32'd0);
        chk("rst_host_beats", host_beats, 32'd0);
`endif
        next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] wd [0:1];
        int nbad;
        for (int i = 0; i < 256; i++) refm[i] = 32'd0;
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 32'd0; host_len = 4'd0; host_wdata = 32'd0;
        repeat (2) @(posedge clk);
        mem_init_done = 1'b1;
        #1;
        apply_reset();

        // CPU-only write then read-back of the same word.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        cpu_check();
        next_cycle();
        cpu_we = 1'b0;
        @(negedge clk);
        chk("cpu_readback", cpu_rdata, 32'hDEADBEEF);
        cpu_check();
        next_cycle();
        idle_cycle(1'b0);

        // Host write then read-back at 0x10, 4 beats.
        run_burst(1'b1, 32'h10, 4'd3, 1'b0, 1'b0);
        run_burst(1'b0, 32'h10, 4'd3, 1'b0, 1'b0);

        // Address wrap across 2^32.
        run_burst(1'b1, 32'hFFFF_FFFE, 4'd3, 1'b0, 1'b0);
        run_burst(1'b0, 32'hFFFF_FFFE, 4'd3, 1'b1, 1'b0);

        // Reset asserted at beat 2 of an 8-beat write.
        wd[0] = $urandom; wd[1] = $urandom;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h40; host_len = 4'd7; host_wdata = wd[0];
        next_cycle();
        host_req = 1'b0;
        @(negedge clk);
        chk("mid_gnt", host_gnt, 1'b1);
        refm[8'h40] = wd[0];
        next_cycle();
        host_wdata = wd[1];
        @(negedge clk);
        chk("mid_beat1_we", mem_we, 1'b1);
        refm[8'h41] = wd[1];
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_we", mem_we, 1'b0);
        chk("mid_rst_wack", host_wack, 1'b0);
        chk("mid_rst_done", host_done, 1'b0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_post_done", host_done, 1'b0);
        chk("mid_post_strobes", {mem_we, mem_re}, 2'b00);
        next_cycle();
        run_burst(1'b0, 32'h40, 4'd2, 1'b0, 1'b0);

        // Contention: CPU busy throughout; starvation forces the grant.
        apply_reset();
        run_burst(1'b1, 32'h90, 4'd3, 1'b1, 1'b0);
`ifdef DMEM_ARB_STATS_EN
        chk("stats_stall_cycles", stall_cycles, 32'd5);
        chk("stats_host_beats", host_beats, 32'd4);
`endif

        // Randomized traffic.
        for (int b = 0; b < 30; b++) begin
            run_burst(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 3)) idle_cycle(1'b1);
        end

        @(negedge clk);
        nbad = 0;
        for (int i = 0; i < 256; i++) if (phys[i] !== refm[i]) nbad++;
        chk("mem_image_mismatches", 64'(nbad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
